// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state and configuration encodings
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_t;
  typedef enum logic [1:0] {STOP_1 = 2'b00, STOP_1P5 = 2'b01, STOP_2 = 2'b10} stop_t;
endpackage

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with runtime data length, parity, stop length and valid/ready
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int SAMPLE = 16,
  parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1),
  parameter int TICK_COUNT_SIZE = $clog2(2 * SAMPLE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_tick,
  input  logic [DATA_SIZE-1:0]      data_in,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic [BIT_COUNT_SIZE-1:0] cfg_data_bits,
  input  logic [1:0]                cfg_parity,
  input  logic [1:0]                cfg_stop,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done_tick
);
  localparam logic [BIT_COUNT_SIZE-1:0] MIN_BITS = BIT_COUNT_SIZE'(5);
  localparam logic [BIT_COUNT_SIZE-1:0] MAX_BITS = BIT_COUNT_SIZE'(DATA_SIZE);
  localparam logic [TICK_COUNT_SIZE-1:0] LAST_1 = TICK_COUNT_SIZE'(SAMPLE - 1);
  localparam logic [TICK_COUNT_SIZE-1:0] LAST_1P5 = TICK_COUNT_SIZE'(3 * SAMPLE / 2 - 1);
  localparam logic [TICK_COUNT_SIZE-1:0] LAST_2 = TICK_COUNT_SIZE'(2 * SAMPLE - 1);
  state_t state;
  logic [TICK_COUNT_SIZE-1:0] tick, stop_last, stop_last_in;
  logic [BIT_COUNT_SIZE-1:0] bit_idx, nbits, nbits_in;
  logic [DATA_SIZE-1:0] shift;
  logic par_en, par_odd, par, bit_end;
  always_comb begin
    nbits_in = cfg_data_bits < MIN_BITS ? MIN_BITS : cfg_data_bits > MAX_BITS ? MAX_BITS : cfg_data_bits;
    stop_last_in = cfg_stop == STOP_1P5 ? LAST_1P5 : cfg_stop == STOP_2 ? LAST_2 : LAST_1;
    bit_end = s_tick && tick == LAST_1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tick <= '0;
      bit_idx <= '0;
      nbits <= '0;
      stop_last <= '0;
      shift <= '0;
      par_en <= 1'b0;
      par_odd <= 1'b0;
      par <= 1'b0;
      tx <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            state <= START;
            tx <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy <= 1'b1;
            tick <= '0;
            bit_idx <= '0;
            shift <= data_in;
            nbits <= nbits_in;
            par_en <= cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD;
            par_odd <= cfg_parity == PAR_ODD;
            stop_last <= stop_last_in;
            par <= 1'b0;
          end
        end
        START: if (bit_end) begin
          tick <= '0;
          state <= DATA;
          tx <= shift[0];
        end else if (s_tick) tick <= tick + 1'b1;
        DATA: if (bit_end) begin
          tick <= '0;
          par <= par ^ shift[0];
          shift <= shift >> 1;
          if (bit_idx == nbits - 1'b1) begin
            state <= par_en ? PARITY : STOP;
            tx <= par_en ? par ^ shift[0] ^ par_odd : 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx <= shift[1];
          end
        end else if (s_tick) tick <= tick + 1'b1;
        PARITY: if (bit_end) begin
          tick <= '0;
          state <= STOP;
          tx <= 1'b1;
        end else if (s_tick) tick <= tick + 1'b1;
        STOP: if (s_tick && tick == stop_last) begin
          // tx_ready rises one clk later, in IDLE
          tick <= '0;
          state <= IDLE;
          tx_busy <= 1'b0;
          tx_done_tick <= 1'b1;
        end else if (s_tick) tick <= tick + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: table, random and corner-case checks of uart_tx_cfg against a tick-level frame model
module tb_uart_tx_cfg;
  logic clk = 0, reset = 1, s_tick = 0, tx_valid = 0;
  logic [7:0] data_in = 0;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 0, cfg_stop = 0;
  logic tx_ready, tx, tx_busy, tx_done_tick;
  int pass_n = 0, total_n = 0, tick_div = 1, lat;
  bit got[$], exp_q[$];

  typedef struct {
    logic [7:0] d;
    int nb, par, stp, lat, nbc;
    bit pbit;
  } vec_t;

  uart_tx_cfg dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .data_in(data_in), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop(cfg_stop), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      s_tick = (tick_div <= 1) || (c % tick_div == 0);
    end
  end

  function automatic void chk(string nm, int act, int req);
    total_n++;
    if (act == req) pass_n++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endfunction

  // expected tx level for every s_tick of a frame, straight from the frame format
  function automatic void build(logic [7:0] d, int nb, int par, int stp);
    int n;
    bit p;
    n = nb < 5 ? 5 : nb > 8 ? 8 : nb;
    p = 0;
    exp_q.delete();
    repeat (16) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      repeat (16) exp_q.push_back(d[i]);
      p ^= d[i];
    end
    if (par == 1 || par == 2) repeat (16) exp_q.push_back(p ^ (par == 2));
    repeat (stp == 1 ? 24 : stp == 2 ? 32 : 16) exp_q.push_back(1'b1);
  endfunction

  function automatic void cmp(string nm);
    int bad;
    bad = -1;
    chk({nm, " len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] != exp_q[i] && bad < 0) bad = i;
    chk({nm, " first_bad_tick"}, bad, -1);
  endfunction

  task automatic start(input logic [7:0] d, input int nb, input int par, input int stp, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", tx_ready, 1);
    data_in = d;
    cfg_data_bits = 4'(nb);
    cfg_parity = 2'(par);
    cfg_stop = 2'(stp);
    tx_valid = 1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 0;
  endtask

  // records tx on each s_tick cycle from the first low clk until tx_done_tick
  task automatic capture(input bit pre, input string nm);
    int n, rb, bb;
    bit done;
    n = 0; rb = 0; bb = 0; done = 0;
    got.delete();
    while (n < 8000 && !done) begin
      if (n > 0 || !pre) @(negedge clk);
      if (tx_ready) rb++;
      if (tx_done_tick) begin
        done = 1;
        chk({nm, " busy_at_done"}, tx_busy, 0);
      end else begin
        if (!tx_busy) bb++;
        if (s_tick) got.push_back(tx);
        n++;
      end
    end
    lat = n;
    chk({nm, " done_seen"}, done, 1);
    chk({nm, " ready_low"}, rb, 0);
    chk({nm, " busy_high"}, bb, 0);
  endtask

  initial begin
    vec_t tv[8];
    int gap, lows, dones;
    logic [7:0] rd;
    int rnb, rpar, rstp;
    tv[0] = '{8'hCB, 8, 0, 0, 160, 8, 1'b0};
    tv[1] = '{8'hCB, 8, 1, 0, 176, 8, 1'b1};
    tv[2] = '{8'hCB, 8, 2, 0, 176, 8, 1'b0};
    tv[3] = '{8'h55, 7, 0, 1, 152, 7, 1'b0};
    tv[4] = '{8'h55, 7, 0, 2, 160, 7, 1'b0};
    tv[5] = '{8'h3C, 3, 0, 0, 112, 5, 1'b0};
    tv[6] = '{8'h0F, 15, 1, 2, 192, 8, 1'b0};
    tv[7] = '{8'h1D, 5, 2, 1, 136, 5, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset tx_ready", tx_ready, 1);
    chk("reset tx_busy", tx_busy, 0);
    chk("reset tx_done_tick", tx_done_tick, 0);
    @(posedge clk);
    #1 reset = 0;

    for (int i = 0; i < 8; i++) begin
      start(tv[i].d, tv[i].nb, tv[i].par, tv[i].stp, 0);
      capture(0, $sformatf("vec%0d", i));
      build(tv[i].d, tv[i].nb, tv[i].par, tv[i].stp);
      cmp($sformatf("vec%0d", i));
      chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
      if (tv[i].par != 0 && got.size() > 16 + 16 * tv[i].nbc + 8)
        chk($sformatf("vec%0d parity", i), got[16 + 16 * tv[i].nbc + 8], tv[i].pbit);
    end

    // held tx_valid: one idle clk between frames, cfg change mid-frame ignored
    start(8'hA5, 8, 0, 0, 1);
    data_in = 8'h3C;
    cfg_parity = 2'd1;
    cfg_stop = 2'd2;
    capture(0, "b2b_a5");
    build(8'hA5, 8, 0, 0);
    cmp("b2b_a5");
    gap = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!tx) break;
      if (tx_ready) gap++;
    end
    chk("b2b idle_gap", gap, 1);
    tx_valid = 0;
    capture(1, "b2b_3c");
    build(8'h3C, 8, 1, 2);
    cmp("b2b_3c");

    // reset during DATA abandons the frame
    start(8'h00, 8, 0, 0, 0);
    repeat (40) @(negedge clk);
    chk("pre_reset tx", tx, 0);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("midreset tx", tx, 1);
    chk("midreset tx_ready", tx_ready, 1);
    chk("midreset tx_busy", tx_busy, 0);
    lows = 0; dones = 0;
    repeat (300) begin
      @(negedge clk);
      if (!tx) lows++;
      if (tx_done_tick) dones++;
    end
    chk("midreset no_done", dones, 0);
    chk("midreset line_idle", lows, 0);
    start(8'h96, 8, 1, 0, 0);
    capture(0, "after_reset");
    build(8'h96, 8, 1, 0);
    cmp("after_reset");

    for (int r = 0; r < 20; r++) begin
      rd = 8'($urandom);
      rnb = $urandom_range(0, 15);
      rpar = $urandom_range(0, 3);
      rstp = $urandom_range(0, 3);
      start(rd, rnb, rpar, rstp, 0);
      capture(0, $sformatf("rnd%0d", r));
      build(rd, rnb, rpar, rstp);
      cmp($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d latency", r), lat, exp_q.size());
    end

    // 50 MHz / 115200 style tick: one s_tick every 27 clk, 3 data bits clamp to 5
    tick_div = 27;
    start(8'hB2, 3, 0, 0, 0);
    capture(0, "slow");
    build(8'hB2, 3, 0, 0);
    cmp("slow");
    chk("slow latency_range", int'(lat >= (exp_q.size() - 1) * 27 && lat <= (exp_q.size() + 1) * 27), 1);
    tick_div = 1;

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Next-generation UART transmitter that serialises one parallel word per frame onto the tx line, paced by the shared 16x oversampling tick (s_tick from uart_sampling_tick). It adds four things to the fixed 8N1 transmitter: runtime-selectable data length, parity (none/even/odd) and stop length (1/1.5/2), plus a valid/ready handshake. It sits between the TX FIFO read side and the pad.

Parameters:
DATA_SIZE, 8, maximum data bits per frame; must be >= 5.
SAMPLE, 16, s_tick pulses per bit period; must be even.
BIT_COUNT_SIZE, $clog2(DATA_SIZE+1), width of the data-length fields and counters.
TICK_COUNT_SIZE, $clog2(2*SAMPLE), width of the tick counter; covers a 2-stop period.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
s_tick  in  1  one-clk oversampling strobe.
data_in  in  DATA_SIZE  word to send; LSB is sent first.
tx_valid  in  1  data_in and the cfg_* inputs are valid.
tx_ready  out  1  block can accept a word.
cfg_data_bits  in  BIT_COUNT_SIZE  data bits per frame, legal range 5..DATA_SIZE.
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
cfg_stop  in  2  00 one stop bit, 01 1.5 stop bits, 10 two stop bits, 11 treated as 1.
tx  out  1  serial line; idles high.
tx_busy  out  1  high while a frame is in progress (any state other than IDLE).
tx_done_tick  out  1  one-clk pulse at the end of the stop period.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done_tick=0, state=IDLE, all counters 0.
- If reset is asserted mid-frame, on the next posedge: tx=1, state=IDLE, the frame is abandoned and no done tick is issued.
- Acceptance happens on a clk where tx_valid && tx_ready. At acceptance the block latches data_in and all cfg_* fields. cfg_* changes during a frame have no effect.
- Clamp cfg_data_bits when latching: a value below 5 is used as 5; a value above DATA_SIZE is used as DATA_SIZE.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: tx=1, tx_ready=1. On acceptance go to START; tx=0 from the next clk. The tick counter clears.
  - Tick counter: increments only on s_tick. A bit ends on the s_tick where the counter equals SAMPLE-1; the counter then clears.
  - START: one bit period, then go to DATA with the bit index at 0.
  - DATA: drive shift[0]; shift right at the end of each bit. After the latched data-bit count of bits, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: drive the even-parity bit (XOR of the sent data bits only) or its inverse for odd parity; one bit period.
  - STOP: tx=1. The stop period is SAMPLE, 3*SAMPLE/2 or 2*SAMPLE ticks. On its final s_tick, pulse tx_done_tick for one clk and go to IDLE.
- tx_ready is low from the clk after acceptance until the clk after tx_done_tick, so back-to-back accept takes one idle clk. A tx_valid held high is accepted in that IDLE cycle; the line then shows a full stop period followed immediately by a start bit.
- s_tick and tx_valid coinciding in IDLE: the s_tick is ignored, because the counter starts at 0 on the START entry clk.
- s_tick is never asserted is a legal case: the block stays in the current state indefinitely.

Decomposition:
- Shared package/include uart_pkg: state encodings; parity codes PAR_NONE/PAR_EVEN/PAR_ODD; stop codes STOP_1/STOP_1P5/STOP_2.
- Parity generation is an inline reduction-XOR over the bits sent, not a separate sub-module.
- uart_sampling_tick stays external, shared with the receiver.
- No sub-module is required; one FSM file.

Test Plan:
(For all scenarios, s_tick is tied to 1 so that 1 bit = 16 clk, unless stated otherwise.)
- 8N1, data_in=0xCB, pulse tx_valid -> tx is 0 for 16 clk, then 1,1,0,1,0,0,1,1 at 16 clk each, then 1 for 16 clk; tx_done_tick fires exactly 160 clk after the first low clk; tx_ready=0 throughout.
- 8E1 0xCB -> parity bit 1; 8O1 0xCB -> parity bit 0; frame 176 clk.
- 7 bits, no parity, STOP_1P5, data 0x55 -> data 1,0,1,0,1,0,1; stop high for 24 clk; done at 152 clk. Repeat with STOP_2 -> done at 160 clk.
- tx_valid held high with words 0xA5 then 0x3C -> exactly one idle clk with tx=1 and tx_ready=1 between done and the next start; both frames correct; cfg change mid-frame ignored.
- Reset asserted during DATA -> tx=1 and tx_ready=1 at the next posedge, no tx_done_tick; the next frame is sent cleanly.
- Real 50 MHz/115200 tick, cfg_data_bits=3 (clamped to 5) -> 5 data bits sent; bit period ≈ 16*27 clk.
